// File: rtl/floating_point_multiplier_if.sv
// Operand/result bundle for the binary32 multiplier: operands in, registered product out.
interface floating_point_multiplier_if;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Product;
    logic        out_valid;

    modport master (output in_valid, A, B, input  Product, out_valid);
    modport slave  (input  in_valid, A, B, output Product, out_valid);
endinterface

// File: rtl/floating_point_multiplier.sv
// Binary32 multiplier: combinational datapath (RNE, flush-to-zero) into one result register.
module floating_point_multiplier (
    input  logic                        clk,
    input  logic                        rst_n,
    floating_point_multiplier_if.slave  bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sign = bus.A[31] ^ bus.B[31];
    assign ea   = bus.A[30:23];
    assign eb   = bus.B[30:23];
    assign fa   = bus.A[22:0];
    assign fb   = bus.B[22:0];

    // Subnormal operands (e=0, f!=0) fall into the zero class.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);

    logic [47:0]       sig_prod;
    logic signed [9:0] exp_sum;

    assign sig_prod = {24'h0, 1'b1, fa} * {24'h0, 1'b1, fb};
    assign exp_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    logic [22:0]       mant;
    logic              guard, sticky;
    logic signed [9:0] exp_norm, exp_fin;
    logic [23:0]       mant_rnd;
    logic [31:0]       result;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        mant     = sig_prod[45:23];
        guard    = sig_prod[22];
        sticky   = |sig_prod[21:0];
        exp_norm = exp_sum;
        if (sig_prod[47]) begin
            mant     = sig_prod[46:24];
            guard    = sig_prod[23];
            sticky   = |sig_prod[22:0];
            exp_norm = exp_sum + 10'sd1;
        end

        // A rounding carry leaves mant_rnd[22:0] at zero, so only the exponent needs bumping.
        mant_rnd = {1'b0, mant} + {23'h0, guard & (sticky | mant[0])};
        exp_fin  = mant_rnd[23] ? exp_norm + 10'sd1 : exp_norm;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            result = QNAN;
        else if (a_inf || b_inf)
            result = {sign, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            result = {sign, 31'h0};
        else if (exp_fin >= 10'sd255)
            result = {sign, 8'hFF, 23'h0};
        else if (exp_fin <= 10'sd0)
            result = {sign, 31'h0};
        else
            result = {sign, exp_fin[7:0], mant_rnd[22:0]};
    end

    logic        running;
    logic        valid_q;
    logic [31:0] product_q;

    // running stays low for the first edge after reset release, so an operation presented on that edge is dropped.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= 32'h0;
        end else begin
            running <= 1'b1;
            valid_q <= bus.in_valid & running;
            if (bus.in_valid && running)
                product_q <= result;
        end
    end

    assign bus.Product   = product_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_floating_point_multiplier.sv
// Self-checking bench: directed vector table, control/reset sequences, random ops vs. an exact-arithmetic model.
module tb_floating_point_multiplier;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    floating_point_multiplier_if bus ();

    floating_point_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
    endtask

    // Exact integer product, rounded by comparing the discarded remainder against one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic            s;
        int              ea, eb, e, k, sh;
        longint unsigned p, q, rem, half;
        logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {s, 31'h0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        k = 0;
        for (int i = 0; i < 64; i++) if (p[i]) k = i;
        sh   = k - 23;
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        e = ea + eb - 127 + (k - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], q[22:0]};
    endfunction

    // Biased toward zeros, specials and extreme exponents so every result class is exercised.
    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          r;
        r = int'($urandom_range(0, 15));
        f = 23'($urandom);
        case (r)
            0:       e = 8'h00;
            1: begin e = 8'hFF; f = 23'h0; end
            2: begin e = 8'hFF; f = f | 23'h1; end
            3:       e = 8'($urandom_range(1, 8));
            4:       e = 8'($urandom_range(246, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    logic [31:0] exp_p;
    logic        v;
    logic [31:0] ra, rb;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{32'h40A80000, 32'h400CCCCD, 32'h4138CCCD};
        vecs[1]  = '{32'hBE99999A, 32'h43FA2000, {1'b1, 8'b10000110, 23'b00101100001001100110100}};
        vecs[2]  = '{32'h00000000, 32'h40A80000, 32'h00000000};
        vecs[3]  = '{32'h40A80000, 32'hC00CCCCD, 32'hC138CCCD};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        vecs[5]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000};
        vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000};
        vecs[9]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000};
        vecs[10] = '{32'hFF800000, 32'h80000000, 32'h7FC00000};
        vecs[11] = '{32'h80000000, 32'h40A80000, 32'h80000000};

        // Reset held across clock edges with a live operation on the inputs.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = vecs[0].a;
        bus.B        = vecs[0].b;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {bus.out_valid, bus.Product}, 33'h0);

        // Operation presented on the release edge is dropped.
        rst_n = 1'b1;
        step(1'b1, vecs[1].a, vecs[1].b);
        check("release_edge_drop", {bus.out_valid, bus.Product}, 33'h0);

        // Directed vectors, issued back to back.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), {bus.out_valid, bus.Product}, {1'b1, vecs[i].p});
        end

        // Idle cycle: Product holds the last result, out_valid drops.
        step(1'b0, 32'h3F800000, 32'h3F800000);
        check("idle_hold", {bus.out_valid, bus.Product}, {1'b0, vecs[11].p});

        // Random mix of valid/idle cycles against the reference model.
        exp_p = vecs[11].p;
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            ra = rand_op();
            rb = rand_op();
            step(v, ra, rb);
            if (v) exp_p = ref_mul(ra, rb);
            check($sformatf("rand%0d a=%h b=%h", n, ra, rb), {bus.out_valid, bus.Product}, {v, exp_p});
        end

        // Asynchronous reset between edges clears outputs without a clock.
        step(1'b1, vecs[0].a, vecs[0].b);
        check("pre_async_reset", {bus.out_valid, bus.Product}, {1'b1, vecs[0].p});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus.out_valid, bus.Product}, 33'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
